// File: rtl/conv_enc_scheduler.sv
// conv_enc_scheduler: runs one code block at a time through the convolutional
// encoder, then drains its three subblock FIFOs and emits the bytes as one
// interleaved stream (d0, d1, d2 per byte position) over valid/ready.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | ready for a request; req_ready high
// S_LOAD      | first cycle of data_valid toward the encoder
// S_WAIT_DONE | data_valid held, waiting for computation_done or timeout
// S_RD        | rdreq_subblock pulse, pops all three FIFOs
// S_CAP       | FIFO outputs valid; capture them, count the position
// S_EMIT0     | presenting subblock 0 byte
// S_EMIT1     | presenting subblock 1 byte
// S_EMIT2     | presenting subblock 2 byte; last of block when nothing left
module conv_enc_scheduler #(
  parameter int SMALL_BYTES = 132,
  parameter int LARGE_BYTES = 768,
  parameter int TIMEOUT     = 16384,
  parameter int CNT_W       = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_len,
  input  logic [7:0] req_tail,
  output logic       data_valid,
  output logic [7:0] tail_byte,
  output logic       code_block_length,
  input  logic       computation_done,
  input  logic [7:0] q0,
  input  logic [7:0] q1,
  input  logic [7:0] q2,
  output logic       rdreq_subblock,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [1:0] out_stream,
  output logic       out_last,
  output logic       busy,
  output logic       timeout_err
);

  localparam logic [CNT_W-1:0] SMALL_CNT = CNT_W'(SMALL_BYTES);
  localparam logic [CNT_W-1:0] LARGE_CNT = CNT_W'(LARGE_BYTES);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT_DONE, S_RD, S_CAP, S_EMIT0, S_EMIT1, S_EMIT2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] bytes_left;
  logic [CNT_W-1:0] tmo_cnt;
  logic [7:0]       h1;
  logic [7:0]       h2;
  logic             out_fire;

  assign out_fire = out_valid && out_ready;

  // Sequencer: all outputs are registered and updated on the transition that
  // enters the state they belong to. Subblock 0 goes straight into out_data at
  // capture; only subblocks 1 and 2 need hold registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      bytes_left        <= '0;
      tmo_cnt           <= '0;
      h1                <= '0;
      h2                <= '0;
      req_ready         <= 1'b0;
      data_valid        <= 1'b0;
      tail_byte         <= '0;
      code_block_length <= 1'b0;
      rdreq_subblock    <= 1'b0;
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_stream        <= '0;
      out_last          <= 1'b0;
      busy              <= 1'b0;
      timeout_err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready         <= 1'b0;
            code_block_length <= req_len;
            tail_byte         <= req_tail;
            bytes_left        <= req_len ? LARGE_CNT : SMALL_CNT;
            timeout_err       <= 1'b0;
            data_valid        <= 1'b1;
            busy              <= 1'b1;
            state             <= S_LOAD;
          end
        end
        S_LOAD: begin
          tmo_cnt <= '0;
          state   <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (computation_done) begin
            data_valid     <= 1'b0;
            rdreq_subblock <= 1'b1;
            state          <= S_RD;
          end else if (tmo_cnt == TMO_LAST) begin
            // Abort without draining; the encoder never finished.
            timeout_err <= 1'b1;
            data_valid  <= 1'b0;
            busy        <= 1'b0;
            req_ready   <= 1'b1;
            state       <= S_IDLE;
          end
        end
        S_RD: begin
          rdreq_subblock <= 1'b0;
          state          <= S_CAP;
        end
        S_CAP: begin
          h1         <= q1;
          h2         <= q2;
          out_data   <= q0;
          out_stream <= 2'd0;
          out_valid  <= 1'b1;
          if (bytes_left != '0) bytes_left <= bytes_left - 1'b1;
          state      <= S_EMIT0;
        end
        S_EMIT0: begin
          if (out_fire) begin
            out_data   <= h1;
            out_stream <= 2'd1;
            state      <= S_EMIT1;
          end
        end
        S_EMIT1: begin
          if (out_fire) begin
            out_data   <= h2;
            out_stream <= 2'd2;
            out_last   <= (bytes_left == '0);
            state      <= S_EMIT2;
          end
        end
        S_EMIT2: begin
          if (out_fire) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (bytes_left != '0) begin
              rdreq_subblock <= 1'b1;
              state          <= S_RD;
            end else begin
              busy      <= 1'b0;
              req_ready <= 1'b1;
              state     <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_enc_scheduler.sv
// Bench for conv_enc_scheduler: random FIFO contents and random backpressure,
// checked against an interleaved expected-byte queue.
`timescale 1ns/1ps
module tb_conv_enc_scheduler;

  localparam int SMALL = 132;
  localparam int LARGE = 768;
  localparam int TMO   = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_len = 1'b0;
  logic [7:0] req_tail = '0;
  logic       computation_done = 1'b0;
  logic [7:0] q0 = '0, q1 = '0, q2 = '0;
  logic       out_ready = 1'b0;

  logic       req_ready, data_valid, code_block_length, rdreq_subblock;
  logic       out_valid, out_last, busy, timeout_err;
  logic [7:0] tail_byte, out_data;
  logic [1:0] out_stream;

  conv_enc_scheduler #(
    .SMALL_BYTES(SMALL), .LARGE_BYTES(LARGE), .TIMEOUT(TMO), .CNT_W(15)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len), .req_tail(req_tail),
    .data_valid(data_valid), .tail_byte(tail_byte), .code_block_length(code_block_length),
    .computation_done(computation_done),
    .q0(q0), .q1(q1), .q2(q2), .rdreq_subblock(rdreq_subblock),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_stream(out_stream), .out_last(out_last),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model state: three FIFOs and the interleaved byte stream they imply.
  logic [7:0] fifo0[$], fifo1[$], fifo2[$], exp_q[$];
  logic [7:0] b0, b1, b2, e_byte, prev_data;
  logic [1:0] prev_stream;
  int  exp_n = 0, exp_total = 0, out_idx = 0, rd_pulses = 0;
  int  done_rd = 0, done_out = 0, blocks_done = 0;
  bit  stall_pending = 0, last_seen = 0;
  bit  bp_mode = 0;

  // Monitor / FIFO model, sampling 1 ns after the falling edge.
  initial begin
    forever begin
      @(negedge clk); #1;
      if (reset) begin
        fifo0.delete(); fifo1.delete(); fifo2.delete(); exp_q.delete();
        stall_pending = 0; last_seen = 0; out_ready = 1'b1;
      end else begin
        if (rdreq_subblock) begin
          rd_pulses++;
          if (fifo0.size() == 0) check("fifo_underflow", rd_pulses, exp_n);
          else begin
            q0 = fifo0.pop_front(); q1 = fifo1.pop_front(); q2 = fifo2.pop_front();
          end
        end
        if (last_seen) begin
          check("busy_after_last", busy, 0);
          check("req_ready_after_last", req_ready, 1);
          last_seen = 0;
        end
        if (stall_pending) begin
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, prev_data);
          check("stall_stream", out_stream, prev_stream);
        end
        if (busy && req_valid) check("req_ready_busy", req_ready, 0);
        out_ready = bp_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("extra_byte", out_idx, exp_total);
          else begin
            e_byte = exp_q.pop_front();
            check("out_data", out_data, e_byte);
            check("out_stream", out_stream, out_idx % 3);
            check("out_last", out_last, (out_idx == exp_total - 1) ? 1 : 0);
            out_idx++;
            if (out_idx == exp_total) begin
              done_rd = rd_pulses; done_out = out_idx; blocks_done++; last_seen = 1;
            end
          end
        end
        stall_pending = out_valid && !out_ready;
        prev_data = out_data;
        prev_stream = out_stream;
        if (req_valid && req_ready) begin
          exp_n = req_len ? LARGE : SMALL;
          exp_total = 3 * exp_n;
          out_idx = 0; rd_pulses = 0;
          fifo0.delete(); fifo1.delete(); fifo2.delete(); exp_q.delete();
          for (int i = 0; i < exp_n; i++) begin
            b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
            fifo0.push_back(b0); fifo1.push_back(b1); fifo2.push_back(b2);
            exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2);
          end
        end
      end
    end
  end

  // Raises a request and returns at the falling edge of the LOAD cycle.
  task automatic start_req(input logic len, input logic [7:0] tail);
    int budget = 0;
    req_valid = 1'b1; req_len = len; req_tail = tail;
    while (req_ready !== 1'b1 && budget < 100) begin @(negedge clk); budget++; end
    check("req_accept_wait", budget < 100, 1);
    @(negedge clk);
    req_valid = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_req_ready", req_ready, 0);
    check("accept_tmo_clear", timeout_err, 0);
  endtask

  // From the LOAD falling edge: hold data_valid a random time, then signal done.
  task automatic finish_enc(input logic len, input logic [7:0] tail);
    int r;
    check("dv_load", data_valid, 1);
    check("tail_load", tail_byte, tail);
    check("len_load", code_block_length, len);
    r = $urandom_range(1, 20);
    repeat (r) begin
      @(negedge clk);
      check("dv_wait", data_valid, 1);
      check("tail_wait", tail_byte, tail);
      check("len_wait", code_block_length, len);
    end
    computation_done = 1'b1;
    @(negedge clk);
    computation_done = 1'b0;
    check("dv_after_done", data_valid, 0);
    check("rdreq_after_done", rdreq_subblock, 1);
  endtask

  task automatic wait_drain(input int n, input int cnt0);
    int budget = 0;
    while (blocks_done == cnt0 && budget < 30000) begin @(negedge clk); budget++; end
    check("drain_wait", budget < 30000, 1);
    check("rdreq_pulses", done_rd, n);
    check("bytes_out", done_out, 3 * n);
  endtask

  task automatic run_block(input logic len, input logic [7:0] tail, input bit bp);
    int cnt0;
    bp_mode = bp;
    cnt0 = blocks_done;
    start_req(len, tail);
    finish_enc(len, tail);
    wait_drain(len ? LARGE : SMALL, cnt0);
  endtask

  initial begin
    int cnt, cnt0;
    logic [7:0] ta, tb;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_tail_byte", tail_byte, 0);
    check("rst_cbl", code_block_length, 0);
    check("rst_rdreq", rdreq_subblock, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_stream", out_stream, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_req_ready", req_ready, 1);

    computation_done = 1'b1;
    @(negedge clk);
    computation_done = 1'b0;
    check("idle_done_busy", busy, 0);
    check("idle_done_rdreq", rdreq_subblock, 0);

    run_block(1'b0, 8'hA5, 1'b0);
    run_block(1'b1, 8'($urandom), 1'b0);
    run_block(1'b0, 8'($urandom), 1'b1);

    // Reset while presenting the subblock 1 byte.
    bp_mode = 0;
    ta = 8'($urandom);
    start_req(1'b0, ta);
    finish_enc(1'b0, ta);
    cnt = 0;
    while (!(out_valid === 1'b1 && out_stream === 2'd1) && cnt < 200) begin
      @(negedge clk); cnt++;
    end
    check("emit1_reached", cnt < 200, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_rdreq", rdreq_subblock, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data_valid", data_valid, 0);
    check("mid_rst_out_last", out_last, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", req_ready, 1);

    // Encoder never finishes: LOAD plus TMO WAIT_DONE cycles of data_valid.
    start_req(1'b0, 8'h3C);
    cnt = 0;
    while (data_valid === 1'b1 && cnt < 200) begin cnt++; @(negedge clk); end
    check("tmo_dv_cycles", cnt, TMO + 1);
    check("tmo_err_set", timeout_err, 1);
    check("tmo_busy", busy, 0);
    check("tmo_req_ready", req_ready, 1);
    check("tmo_no_rdreq", rd_pulses, 0);
    @(negedge clk);
    check("tmo_err_sticky", timeout_err, 1);
    run_block(1'b0, 8'($urandom), 1'b0);

    // Second request held high through the drain of the first.
    bp_mode = 1;
    ta = 8'($urandom);
    tb = 8'($urandom);
    cnt0 = blocks_done;
    start_req(1'b0, ta);
    req_valid = 1'b1; req_len = 1'b1; req_tail = tb;
    finish_enc(1'b0, ta);
    wait_drain(SMALL, cnt0);
    @(negedge clk);
    check("held_start_dv", data_valid, 1);
    req_valid = 1'b0;
    bp_mode = 0;
    cnt0 = blocks_done;
    finish_enc(1'b1, tb);
    wait_drain(LARGE, cnt0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

endmodule
